// File: rtl/vector_addition_unit_seq_if.sv
// Request/result bundle for the multi-beat vector adder.
// slave is the unit side; master is the issuing/writeback side.
interface vector_addition_unit_seq_if #(
    parameter int VLEN   = 512,
    parameter int LANE_W = 128
);
    localparam int NBEATS = VLEN / LANE_W;
    localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    logic              flush_i;
    logic              valid_i;
    logic              ready_o;
    logic [VLEN-1:0]   vs2_i;
    logic [VLEN-1:0]   vs1_i;
    logic [VLEN/8-1:0] vmask_i;
    logic [1:0]        vsew_i;
    logic              add_sub_i;
    logic              reversed_i;
    logic              with_carry_borrow_i;
    logic              compute_carry_i;
    logic              valid_o;
    logic              ready_i;
    logic [LANE_W-1:0] vd_o;
    logic [BEAT_W-1:0] beat_o;
    logic              last_o;
    logic              busy_o;

    modport master (
        output flush_i, valid_i, vs2_i, vs1_i, vmask_i, vsew_i, add_sub_i,
               reversed_i, with_carry_borrow_i, compute_carry_i, ready_i,
        input  ready_o, valid_o, vd_o, beat_o, last_o, busy_o
    );

    modport slave (
        input  flush_i, valid_i, vs2_i, vs1_i, vmask_i, vsew_i, add_sub_i,
               reversed_i, with_carry_borrow_i, compute_carry_i, ready_i,
        output ready_o, valid_o, vd_o, beat_o, last_o, busy_o
    );
endinterface

// File: rtl/vector_addition_unit_seq.sv
// Multi-beat vector add/sub unit: captures a whole VLEN operand group, then
// works through it LANE_W bits per cycle, streaming sums or a packed
// carry/borrow mask to writeback.
module vector_addition_unit_seq #(
    parameter int VLEN   = 512,
    parameter int LANE_W = 128
) (
    input  logic clk_i,
    input  logic rst_i,
    vector_addition_unit_seq_if.slave bus
);
    localparam int NBEATS     = VLEN / LANE_W;
    localparam int BEAT_W     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int MASK_W     = VLEN / 8;
    localparam int MIDX_W     = $clog2(MASK_W);
    localparam int LANE_BYTES = LANE_W / 8;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state;
    state_t            state_next;
    logic [BEAT_W-1:0] beat_cnt;
    logic [LANE_W-1:0] op_vs2 [NBEATS];
    logic [LANE_W-1:0] op_vs1 [NBEATS];
    logic [MASK_W-1:0] op_mask;
    logic [1:0]        op_sew;
    logic              op_sub;
    logic              op_rev;
    logic              op_wcb;
    logic              op_cc;
    logic [MASK_W-1:0] acc;
    logic              out_valid;
    logic [LANE_W-1:0] out_vd;
    logic [BEAT_W-1:0] out_beat;
    logic              out_last;

    logic              kill;
    logic              accept;
    logic              accumulate;
    logic              load_beat;
    logic              load_acc;
    logic              retire;

    logic [LANE_W-1:0] lane_x;
    logic [LANE_W-1:0] lane_y;
    logic [LANE_W-1:0] lane_res;
    logic [MASK_W-1:0] lane_carry;
    logic [MIDX_W-1:0] m_idx;
    logic [8:0]        byte_sum;
    logic [7:0]        y_byte;
    logic              chain;
    logic              cin;
    int                sew_m1;

    assign kill = rst_i | bus.flush_i;

    // Byte-wide ripple over the current beat; the chain restarts at each element boundary with the (inverted for subtract) mask carry-in.
    always_comb begin
        lane_x     = (op_sub && op_rev) ? op_vs1[beat_cnt] : op_vs2[beat_cnt];
        lane_y     = (op_sub && op_rev) ? op_vs2[beat_cnt] : op_vs1[beat_cnt];
        lane_res   = '0;
        lane_carry = '0;
        m_idx      = '0;
        byte_sum   = '0;
        y_byte     = '0;
        chain      = 1'b0;
        cin        = 1'b0;
        sew_m1     = (1 << op_sew) - 1;
        for (int k = 0; k < LANE_BYTES; k++) begin
            m_idx = MIDX_W'((int'(beat_cnt) * LANE_BYTES + k) >> op_sew);
            if ((k & sew_m1) == 0) begin
                cin   = op_wcb & op_mask[m_idx];
                chain = op_sub ? ~cin : cin;
            end
            y_byte   = op_sub ? ~lane_y[k*8 +: 8] : lane_y[k*8 +: 8];
            byte_sum = {1'b0, lane_x[k*8 +: 8]} + {1'b0, y_byte} + {8'd0, chain};
            lane_res[k*8 +: 8] = byte_sum[7:0];
            chain    = byte_sum[8];
            if ((k & sew_m1) == sew_m1) begin
                lane_carry[m_idx] = op_sub ? ~chain : chain;
            end
        end
    end

    // Next-state logic and datapath strobes for the IDLE/RUN/DRAIN sequence.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        accumulate = 1'b0;
        load_beat  = 1'b0;
        load_acc   = 1'b0;
        retire     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.valid_i) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (op_cc) begin
                    accumulate = 1'b1;
                    if (beat_cnt == LAST_BEAT) state_next = DRAIN;
                end else if (!out_valid || bus.ready_i) begin
                    load_beat = 1'b1;
                    if (beat_cnt == LAST_BEAT) state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!out_valid) begin
                    load_acc = 1'b1;
                end else if (bus.ready_i) begin
                    retire     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register; flush behaves exactly like reset.
    always_ff @(posedge clk_i) begin
        if (kill) state <= IDLE;
        else      state <= state_next;
    end

    // Operand and control capture at acceptance; later input changes are ignored.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            for (int b = 0; b < NBEATS; b++) begin
                op_vs2[b] <= bus.vs2_i[b*LANE_W +: LANE_W];
                op_vs1[b] <= bus.vs1_i[b*LANE_W +: LANE_W];
            end
            op_mask <= bus.vmask_i;
            op_sew  <= bus.vsew_i;
            op_sub  <= bus.add_sub_i;
            op_rev  <= bus.reversed_i;
            op_wcb  <= bus.with_carry_borrow_i;
            op_cc   <= bus.compute_carry_i;
        end
    end

    // Beat counter, carry accumulator and the held output register.
    always_ff @(posedge clk_i) begin
        if (kill) begin
            beat_cnt  <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_vd    <= '0;
            out_beat  <= '0;
            out_last  <= 1'b0;
        end else begin
            if (accept) begin
                beat_cnt <= '0;
                acc      <= '0;
            end
            if (accumulate) begin
                acc      <= acc | lane_carry;
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (load_beat) begin
                out_vd    <= lane_res;
                out_beat  <= beat_cnt;
                out_last  <= (beat_cnt == LAST_BEAT);
                out_valid <= 1'b1;
                beat_cnt  <= beat_cnt + 1'b1;
            end
            if (load_acc) begin
                out_vd    <= LANE_W'(acc);
                out_beat  <= '0;
                out_last  <= 1'b1;
                out_valid <= 1'b1;
            end
            if (retire) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

    assign bus.ready_o = (state == IDLE);
    assign bus.busy_o  = (state != IDLE);
    assign bus.valid_o = out_valid;
    assign bus.vd_o    = out_vd;
    assign bus.beat_o  = out_beat;
    assign bus.last_o  = out_last;
endmodule

// File: tb/tb_vector_addition_unit_seq.sv
// Self-checking bench for vector_addition_unit_seq: directed cases plus
// randomized operations compared against an element-level arithmetic model.
module tb_vector_addition_unit_seq;
    localparam int VLEN   = 512;
    localparam int LANE_W = 128;
    localparam int NBEATS = VLEN / LANE_W;
    localparam int MASK_W = VLEN / 8;

    logic clk;
    logic rst;
    int   compare_count;
    int   err_count;
    int   wait_n;

    logic [VLEN-1:0]   cur_vs2;
    logic [VLEN-1:0]   cur_vs1;
    logic [MASK_W-1:0] cur_mask;
    logic [1:0]        cur_sew;
    logic              cur_sub;
    logic              cur_rev;
    logic              cur_wcb;
    logic              cur_cc;
    logic [VLEN-1:0]   exp_res;
    logic [MASK_W-1:0] exp_carry;

    logic [VLEN-1:0]   r_vs2;
    logic [VLEN-1:0]   r_vs1;
    logic [VLEN-1:0]   r_tmp;

    vector_addition_unit_seq_if #(.VLEN(VLEN), .LANE_W(LANE_W)) bus ();

    vector_addition_unit_seq #(.VLEN(VLEN), .LANE_W(LANE_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [LANE_W-1:0] obs, input logic [LANE_W-1:0] expv);
        compare_count++;
        assert (obs === expv) else begin
            err_count++;
            $error("[TB] FAIL %s: got %0h, expected %0h", tag, obs, expv);
        end
    endtask

    task automatic randVec(output logic [VLEN-1:0] v);
        for (int i = 0; i < VLEN / 32; i++) v[i*32 +: 32] = $urandom();
    endtask

    // Element-by-element reference: plain wide arithmetic per SEW element.
    task automatic modelOp(input logic [VLEN-1:0] vs2, input logic [VLEN-1:0] vs1,
                           input logic [MASK_W-1:0] vm, input logic [1:0] sew,
                           input logic sub, input logic rev, input logic wcb,
                           output logic [VLEN-1:0] res, output logic [MASK_W-1:0] carries);
        int         w;
        logic [6:0] wb;
        logic [64:0] emask, x, y, t, cin, r;
        w       = 8 << sew;
        wb      = 7'(w);
        emask   = (65'd1 << w) - 65'd1;
        res     = '0;
        carries = '0;
        for (int e = 0; e < VLEN / w; e++) begin
            x = 65'(vs2 >> (e * w)) & emask;
            y = 65'(vs1 >> (e * w)) & emask;
            if (sub && rev) begin
                t = x;
                x = y;
                y = t;
            end
            cin = {64'd0, wcb & vm[e]};
            if (!sub) begin
                r = x + y + cin;
                carries[e] = r[wb];
            end else begin
                r = x - y - cin;
                carries[e] = (x < y + cin);
            end
            res = res | (VLEN'(r & emask) << (e * w));
        end
    endtask

    task automatic applyStimulus(input logic [VLEN-1:0] vs2, input logic [VLEN-1:0] vs1,
                                 input logic [MASK_W-1:0] vm, input logic [1:0] sew,
                                 input logic sub, input logic rev, input logic wcb, input logic cc);
        logic [VLEN-1:0] junk;
        cur_vs2 = vs2; cur_vs1 = vs1; cur_mask = vm; cur_sew = sew;
        cur_sub = sub; cur_rev = rev; cur_wcb = wcb; cur_cc = cc;
        modelOp(vs2, vs1, vm, sew, sub, rev, wcb, exp_res, exp_carry);
        checkOutput("idle ready_o", LANE_W'(bus.ready_o), LANE_W'(1));
        bus.vs2_i = vs2;
        bus.vs1_i = vs1;
        bus.vmask_i = vm;
        bus.vsew_i = sew;
        bus.add_sub_i = sub;
        bus.reversed_i = rev;
        bus.with_carry_borrow_i = wcb;
        bus.compute_carry_i = cc;
        bus.valid_i = 1'b1;
        step();
        bus.valid_i = 1'b0;
        randVec(junk);
        bus.vs2_i = junk;
        randVec(junk);
        bus.vs1_i = junk;
        bus.vmask_i = junk[MASK_W-1:0];
        bus.vsew_i = 2'($urandom_range(0, 3));
        bus.add_sub_i = 1'($urandom_range(0, 1));
        bus.reversed_i = 1'($urandom_range(0, 1));
        bus.with_carry_borrow_i = 1'($urandom_range(0, 1));
        bus.compute_carry_i = 1'($urandom_range(0, 1));
    endtask

    // Drains one operation; ready policy 0=always, 1=random, 2=stall 3 cycles on beat 1.
    task automatic collectResult(input string name, input int ready_mode);
        int expect_beats = cur_cc ? 1 : NBEATS;
        int expect_lat   = cur_cc ? NBEATS + 1 : 1;
        int got   = 0;
        int cyc   = 0;
        int stall = 3;
        bit seen  = 0;
        logic rdy;
        logic [LANE_W-1:0] exp_vd;
        while (got < expect_beats && cyc < 300) begin
            checkOutput({name, " busy ready_o"}, LANE_W'(bus.ready_o), LANE_W'(0));
            checkOutput({name, " busy_o"}, LANE_W'(bus.busy_o), LANE_W'(1));
            if (bus.valid_o) begin
                if (!seen) begin
                    checkOutput({name, " latency"}, LANE_W'(cyc), LANE_W'(expect_lat));
                    seen = 1;
                end
                exp_vd = cur_cc ? LANE_W'(exp_carry) : exp_res[got*LANE_W +: LANE_W];
                checkOutput({name, " vd_o"}, bus.vd_o, exp_vd);
                checkOutput({name, " beat_o"}, LANE_W'(bus.beat_o), cur_cc ? LANE_W'(0) : LANE_W'(got));
                checkOutput({name, " last_o"}, LANE_W'(bus.last_o),
                            LANE_W'(cur_cc || (got == NBEATS - 1)));
                if (ready_mode == 0) rdy = 1'b1;
                else if (ready_mode == 1) rdy = 1'($urandom_range(0, 1));
                else if (got == 1 && stall > 0) begin
                    rdy = 1'b0;
                    stall--;
                end else rdy = 1'b1;
                bus.ready_i = rdy;
                if (rdy) got++;
            end else begin
                if (seen && !cur_cc) checkOutput({name, " valid gap"}, LANE_W'(bus.valid_o), LANE_W'(1));
                bus.ready_i = 1'($urandom_range(0, 1));
            end
            step();
            cyc++;
        end
        checkOutput({name, " beats done"}, LANE_W'(got), LANE_W'(expect_beats));
        checkOutput({name, " end ready_o"}, LANE_W'(bus.ready_o), LANE_W'(1));
        checkOutput({name, " end busy_o"}, LANE_W'(bus.busy_o), LANE_W'(0));
        checkOutput({name, " end valid_o"}, LANE_W'(bus.valid_o), LANE_W'(0));
        bus.ready_i = 1'b0;
    endtask

    // Directed sequence followed by randomized operations.
    initial begin
        compare_count = 0;
        err_count     = 0;
        rst = 1'b1;
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b0;
        bus.vs2_i = '0;
        bus.vs1_i = '0;
        bus.vmask_i = '0;
        bus.vsew_i = '0;
        bus.add_sub_i = 1'b0;
        bus.reversed_i = 1'b0;
        bus.with_carry_borrow_i = 1'b0;
        bus.compute_carry_i = 1'b0;
        repeat (2) step();
        checkOutput("reset ready_o", LANE_W'(bus.ready_o), LANE_W'(1));
        checkOutput("reset valid_o", LANE_W'(bus.valid_o), LANE_W'(0));
        checkOutput("reset vd_o", bus.vd_o, LANE_W'(0));
        checkOutput("reset beat_o", LANE_W'(bus.beat_o), LANE_W'(0));
        checkOutput("reset last_o", LANE_W'(bus.last_o), LANE_W'(0));
        checkOutput("reset busy_o", LANE_W'(bus.busy_o), LANE_W'(0));
        rst = 1'b0;
        step();

        applyStimulus({64{8'hFF}}, {64{8'h01}}, '0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        collectResult("add8", 0);
        applyStimulus({64{8'hFF}}, {64{8'h01}}, {8{8'hAA}}, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        collectResult("carry8", 0);
        applyStimulus({8{64'd5}}, {8{64'd3}}, '0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1);
        collectResult("rsub64", 0);
        applyStimulus({8{64'd5}}, {8{64'd3}}, '0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1);
        collectResult("sub64", 0);
        randVec(r_vs2);
        randVec(r_vs1);
        applyStimulus(r_vs2, r_vs1, '0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        collectResult("stall32", 2);
        applyStimulus('0, '0, '1, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0);
        collectResult("borrow16", 0);

        randVec(r_vs2);
        randVec(r_vs1);
        applyStimulus(r_vs2, r_vs1, '0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.ready_i = 1'b1;
        wait_n = 0;
        while (!(bus.valid_o && bus.beat_o == 2) && wait_n < 50) begin
            step();
            wait_n++;
        end
        checkOutput("flush reach beat2", LANE_W'(bus.beat_o), LANE_W'(2));
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        bus.ready_i = 1'b0;
        checkOutput("flush valid_o", LANE_W'(bus.valid_o), LANE_W'(0));
        checkOutput("flush ready_o", LANE_W'(bus.ready_o), LANE_W'(1));
        checkOutput("flush busy_o", LANE_W'(bus.busy_o), LANE_W'(0));
        randVec(r_vs2);
        randVec(r_vs1);
        applyStimulus(r_vs2, r_vs1, '0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        collectResult("after flush", 0);

        randVec(r_vs2);
        randVec(r_vs1);
        randVec(r_tmp);
        applyStimulus(r_vs2, r_vs1, r_tmp[MASK_W-1:0], 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        bus.ready_i = 1'b0;
        wait_n = 0;
        while (!bus.valid_o && wait_n < 50) begin
            step();
            wait_n++;
        end
        checkOutput("drain reached", LANE_W'(bus.valid_o), LANE_W'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("rst drain valid_o", LANE_W'(bus.valid_o), LANE_W'(0));
        checkOutput("rst drain ready_o", LANE_W'(bus.ready_o), LANE_W'(1));
        checkOutput("rst drain busy_o", LANE_W'(bus.busy_o), LANE_W'(0));
        checkOutput("rst drain vd_o", bus.vd_o, LANE_W'(0));
        checkOutput("rst drain last_o", LANE_W'(bus.last_o), LANE_W'(0));
        applyStimulus(r_vs2, r_vs1, r_tmp[MASK_W-1:0], 2'b10, 1'b1, 1'b1, 1'b1, 1'b1);
        collectResult("after reset", 1);

        for (int i = 0; i < 24; i++) begin
            randVec(r_vs2);
            randVec(r_vs1);
            randVec(r_tmp);
            applyStimulus(r_vs2, r_vs1, r_tmp[MASK_W-1:0], 2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            collectResult("random", int'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, err_count);
        $finish;
    end
endmodule
